// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard unit: EX operand forwarding, load-use and divider-scoreboard stalls.
// Optional saturating stall counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_fwd_unit #(
  parameter int unsigned NUM_FWD_STAGES = 2,
  parameter int unsigned FW             = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_FWD_STAGES-1:0]   stg_regwrite,
  input  logic [5*NUM_FWD_STAGES-1:0] stg_rd,
  input  logic [4:0]                  id_ex_rs1,
  input  logic [4:0]                  id_ex_rs2,
  input  logic                        id_ex_memread,
  input  logic [4:0]                  id_ex_rd,
  input  logic [4:0]                  if_id_rs1,
  input  logic [4:0]                  if_id_rs2,
  input  logic [4:0]                  if_id_rd,
  input  logic                        if_id_is_div,
  input  logic                        div_start,
  input  logic [4:0]                  div_rd,
  input  logic                        div_done,
  output logic [FW-1:0]               forwardA,
  output logic [FW-1:0]               forwardB,
  output logic                        stall,
  output logic                        div_busy
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]                 stall_cnt
`endif
);

  localparam int unsigned RW = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [RW-1:0] r_pend_rd;
  logic [RW-1:0] w_pend_nxt;

  logic w_load_use;
  logic w_pend_hit;
  logic w_launch_hit;
  logic w_sb_hit;
  logic w_struct_hit;

  // Walk oldest to youngest so the youngest matching stage wins.
  always_comb begin
    forwardA = '0;
    forwardB = '0;
    for (int i = NUM_FWD_STAGES - 1; i >= 0; i--) begin
      if (stg_regwrite[i] && (stg_rd[RW*i +: RW] != '0)) begin
        if (stg_rd[RW*i +: RW] == id_ex_rs1) forwardA = FW'(int'(NUM_FWD_STAGES) - i);
        if (stg_rd[RW*i +: RW] == id_ex_rs2) forwardB = FW'(int'(NUM_FWD_STAGES) - i);
      end
    end
  end

  assign w_load_use = id_ex_memread && (id_ex_rd != '0) &&
                      ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));

  assign w_pend_hit = (r_state == BUSY) && (r_pend_rd != '0) &&
                      ((r_pend_rd == if_id_rs1) || (r_pend_rd == if_id_rs2) ||
                       (r_pend_rd == if_id_rd));

  // The launching divide is not yet in the scoreboard, so check it directly.
  assign w_launch_hit = div_start && (div_rd != '0) &&
                        ((div_rd == if_id_rs1) || (div_rd == if_id_rs2) ||
                         (div_rd == if_id_rd));

  assign w_sb_hit     = w_pend_hit || w_launch_hit;
  assign w_struct_hit = if_id_is_div && ((r_state == BUSY) || div_start);
  assign stall        = w_load_use || w_sb_hit || w_struct_hit;
  assign div_busy     = (r_state == BUSY);

  // Scoreboard next state; a done coinciding with a start hands over to the new divide.
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend_rd;
    case (r_state)
      IDLE: begin
        if (div_start) begin
          w_state_nxt = BUSY;
          w_pend_nxt  = div_rd;
        end
      end
      BUSY: begin
        if (div_done) begin
          if (div_start) begin
            w_pend_nxt = div_rd;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_pend_rd <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pend_rd <= w_pend_nxt;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: vector table, directed divider
// sequences, and randomized traffic against a rule-level reference model.
module tb_hazard_fwd_unit;

  localparam int unsigned N  = 2;
  localparam int unsigned FW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   stg_regwrite;
  logic [5*N-1:0] stg_rd;
  logic [4:0]     id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic           id_ex_memread;
  logic [4:0]     if_id_rs1, if_id_rs2, if_id_rd;
  logic           if_id_is_div;
  logic           div_start, div_done;
  logic [4:0]     div_rd;
  logic [FW-1:0]  forwardA, forwardB;
  logic           stall, div_busy;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0]    stall_cnt;
  longint         m_cnt;
`endif

  hazard_fwd_unit #(.NUM_FWD_STAGES(N)) dut (
    .clk(clk), .rst(rst),
    .stg_regwrite(stg_regwrite), .stg_rd(stg_rd),
    .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2), .if_id_rd(if_id_rd),
    .if_id_is_div(if_id_is_div),
    .div_start(div_start), .div_rd(div_rd), .div_done(div_done),
    .forwardA(forwardA), .forwardB(forwardB),
    .stall(stall), .div_busy(div_busy)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference scoreboard: is a divide outstanding, and which register it writes.
  bit       m_busy;
  int       m_pend;

  typedef struct {
    logic [1:0] rw;
    logic [9:0] rd;
    logic [4:0] rs1, rs2;
    logic       mr;
    logic [4:0] exrd, ifrs1, ifrs2;
    logic [1:0] ea, eb;
    logic       es;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_fwd(input int rs);
    for (int i = 0; i < int'(N); i++) begin
      int rd;
      rd = int'(stg_rd[5*i +: 5]);
      if (stg_regwrite[i] && rd != 0 && rd == rs) return int'(N) - i;
    end
    return 0;
  endfunction

  function automatic bit reads_or_writes(input int r);
    return (r == int'(if_id_rs1)) || (r == int'(if_id_rs2)) || (r == int'(if_id_rd));
  endfunction

  function automatic bit ref_stall();
    bit lu, sb, st;
    lu = id_ex_memread && id_ex_rd != 0 &&
         (id_ex_rd == if_id_rs1 || id_ex_rd == if_id_rs2);
    sb = (m_busy && m_pend != 0 && reads_or_writes(m_pend)) ||
         (div_start && div_rd != 0 && reads_or_writes(int'(div_rd)));
    st = if_id_is_div && (m_busy || div_start);
    return lu || sb || st;
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_pend = 0;
`ifdef HAZARD_STALL_CNT_EN
    m_cnt  = 0;
`endif
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".forwardA"}, longint'(forwardA), longint'(ref_fwd(int'(id_ex_rs1))));
    chk({tag, ".forwardB"}, longint'(forwardB), longint'(ref_fwd(int'(id_ex_rs2))));
    chk({tag, ".stall"},    longint'(stall),    longint'(ref_stall()));
    chk({tag, ".div_busy"}, longint'(div_busy), longint'(m_busy));
`ifdef HAZARD_STALL_CNT_EN
    chk({tag, ".stall_cnt"}, longint'(stall_cnt), m_cnt);
`endif
  endtask

  // One rising edge with the model following the same inputs, back to the falling edge.
  task automatic advance();
    bit s;
    @(posedge clk);
    s = ref_stall();
`ifdef HAZARD_STALL_CNT_EN
    if (s && m_cnt != 64'h0000_0000_FFFF_FFFF) m_cnt++;
`endif
    if (!m_busy) begin
      if (div_start) begin
        m_busy = 1'b1;
        m_pend = int'(div_rd);
      end
    end else if (div_done) begin
      if (div_start) m_pend = int'(div_rd);
      else           m_busy = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    stg_regwrite = '0; stg_rd = '0;
    id_ex_rs1 = '0; id_ex_rs2 = '0; id_ex_rd = '0; id_ex_memread = 1'b0;
    if_id_rs1 = '0; if_id_rs2 = '0; if_id_rd = '0; if_id_is_div = 1'b0;
    div_start = 1'b0; div_done = 1'b0; div_rd = '0;
  endtask

  initial begin
    tbl[0] = '{2'b11, {5'd5, 5'd5}, 5'd5,  5'd0, 1'b0, 5'd0,  5'd0,  5'd0,  2'b10, 2'b00, 1'b0};
    tbl[1] = '{2'b10, {5'd5, 5'd5}, 5'd5,  5'd0, 1'b0, 5'd0,  5'd0,  5'd0,  2'b01, 2'b00, 1'b0};
    tbl[2] = '{2'b11, {5'd0, 5'd0}, 5'd0,  5'd0, 1'b0, 5'd0,  5'd0,  5'd0,  2'b00, 2'b00, 1'b0};
    tbl[3] = '{2'b11, {5'd3, 5'd7}, 5'd3,  5'd7, 1'b0, 5'd0,  5'd0,  5'd0,  2'b01, 2'b10, 1'b0};
    tbl[4] = '{2'b01, {5'd7, 5'd7}, 5'd7,  5'd7, 1'b0, 5'd0,  5'd0,  5'd0,  2'b10, 2'b10, 1'b0};
    tbl[5] = '{2'b00, {5'd4, 5'd4}, 5'd4,  5'd4, 1'b0, 5'd0,  5'd0,  5'd0,  2'b00, 2'b00, 1'b0};
    tbl[6] = '{2'b00, {5'd0, 5'd0}, 5'd0,  5'd0, 1'b1, 5'd7,  5'd0,  5'd7,  2'b00, 2'b00, 1'b1};
    tbl[7] = '{2'b00, {5'd0, 5'd0}, 5'd0,  5'd0, 1'b1, 5'd0,  5'd0,  5'd7,  2'b00, 2'b00, 1'b0};
    tbl[8] = '{2'b00, {5'd0, 5'd0}, 5'd0,  5'd0, 1'b0, 5'd7,  5'd7,  5'd0,  2'b00, 2'b00, 1'b0};
    tbl[9] = '{2'b10, {5'd12, 5'd1}, 5'd12, 5'd1, 1'b1, 5'd12, 5'd12, 5'd3, 2'b01, 2'b00, 1'b1};

    clear_inputs();
    rst = 1'b0;
    model_reset();
    #1;
    chk("reset.div_busy", longint'(div_busy), 0);
    chk("reset.stall",    longint'(stall),    0);
`ifdef HAZARD_STALL_CNT_EN
    chk("reset.stall_cnt", longint'(stall_cnt), 0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // Forwarding and load-use vectors with an idle scoreboard.
    for (int k = 0; k < 10; k++) begin
      stg_regwrite = tbl[k].rw;   stg_rd    = tbl[k].rd;
      id_ex_rs1    = tbl[k].rs1;  id_ex_rs2 = tbl[k].rs2;
      id_ex_memread = tbl[k].mr;  id_ex_rd  = tbl[k].exrd;
      if_id_rs1    = tbl[k].ifrs1; if_id_rs2 = tbl[k].ifrs2;
      #1;
      chk($sformatf("vec%0d.forwardA", k), longint'(forwardA), longint'(tbl[k].ea));
      chk($sformatf("vec%0d.forwardB", k), longint'(forwardB), longint'(tbl[k].eb));
      chk($sformatf("vec%0d.stall", k),    longint'(stall),    longint'(tbl[k].es));
      advance();
    end
    clear_inputs();

    // Divide with a dependent ID instruction, then completion.
    if_id_rs1 = 5'd9; div_start = 1'b1; div_rd = 5'd9; #1;
    chk("div.launch.stall", longint'(stall), 1);
    chk("div.launch.busy",  longint'(div_busy), 0);
    advance();
    div_start = 1'b0; #1;
    chk("div.busy1.stall", longint'(stall), 1);
    chk("div.busy1.busy",  longint'(div_busy), 1);
    advance();
    #1; check_all("div.busy2");
    div_done = 1'b1; #1; check_all("div.done");
    advance();
    div_done = 1'b0; #1;
    chk("div.after.stall", longint'(stall), 0);
    chk("div.after.busy",  longint'(div_busy), 0);
    advance();

    // Back-to-back divide: done and start share a cycle.
    div_start = 1'b1; div_rd = 5'd9; if_id_rs1 = 5'd0; advance();
    div_start = 1'b1; div_rd = 5'd4; div_done = 1'b1; #1; check_all("b2b.handover");
    advance();
    div_start = 1'b0; div_done = 1'b0; if_id_rs1 = 5'd9; #1;
    chk("b2b.old_rd.stall", longint'(stall), 0);
    chk("b2b.busy",         longint'(div_busy), 1);
    if_id_rs1 = 5'd0; if_id_rd = 5'd4; #1;
    chk("b2b.waw.stall", longint'(stall), 1);
    if_id_rd = 5'd0; if_id_is_div = 1'b1; #1;
    chk("b2b.struct.stall", longint'(stall), 1);
    if_id_is_div = 1'b0; div_start = 1'b1; div_rd = 5'd6; #1;
    check_all("b2b.ignored_start");
    advance();
    div_start = 1'b0; if_id_rs2 = 5'd6; #1;
    chk("b2b.ignored.stall", longint'(stall), 0);
    advance();

    // Asynchronous reset in the middle of a divide.
    chk("rst.pre.busy", longint'(div_busy), 1);
    if_id_rs2 = 5'd4;
    #2 rst = 1'b0;
    #1;
    chk("rst.async.busy",  longint'(div_busy), 0);
    chk("rst.async.stall", longint'(stall), 0);
`ifdef HAZARD_STALL_CNT_EN
    chk("rst.async.stall_cnt", longint'(stall_cnt), 0);
`endif
    model_reset();
    @(negedge clk);
    div_start = 1'b1; div_rd = 5'd4; #1;
    chk("rst.launch_hit.stall", longint'(stall), 1);
    div_start = 1'b0; #1;
    rst = 1'b1;
    #1; check_all("rst.released");
    advance();
    clear_inputs();

`ifdef HAZARD_STALL_CNT_EN
    id_ex_memread = 1'b1; id_ex_rd = 5'd3; if_id_rs1 = 5'd3;
    for (int k = 0; k < 3; k++) advance();
    id_ex_memread = 1'b0; #1;
    chk("cnt.three", longint'(stall_cnt), m_cnt);
    chk("cnt.three_abs", longint'(stall_cnt) - longint'(m_cnt) + 3, 3);
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1 release dut.r_stall_cnt;
    m_cnt = 64'h0000_0000_FFFF_FFFE;
    id_ex_memread = 1'b1;
    for (int k = 0; k < 3; k++) advance();
    #1;
    chk("cnt.saturate", longint'(stall_cnt), 64'h0000_0000_FFFF_FFFF);
    clear_inputs();
    advance();
`endif

    // Randomized traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      stg_regwrite  = N'($urandom);
      for (int s = 0; s < int'(N); s++) stg_rd[5*s +: 5] = 5'($urandom_range(0, 7));
      id_ex_rs1     = 5'($urandom_range(0, 7));
      id_ex_rs2     = 5'($urandom_range(0, 7));
      id_ex_rd      = 5'($urandom_range(0, 7));
      id_ex_memread = ($urandom_range(0, 3) == 0);
      if_id_rs1     = 5'($urandom_range(0, 7));
      if_id_rs2     = 5'($urandom_range(0, 7));
      if_id_rd      = 5'($urandom_range(0, 7));
      if_id_is_div  = ($urandom_range(0, 5) == 0);
      div_start     = ($urandom_range(0, 5) == 0);
      div_rd        = 5'($urandom_range(0, 7));
      div_done      = ($urandom_range(0, 4) == 0);
      #1;
      check_all($sformatf("rand%0d", k));
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
